// File: rtl/startup_done_pattern_gen.sv
// DONE-pin pattern generator for the STARTUPE2 USRDONEO/USRDONETS pins.
// A prescaler produces a one-cycle tick; on each tick the active mode
// (off, blink, fixed pattern, pulse-count code) advances by one step.
// A newly requested mode is only adopted at the end of the running sequence.
module startup_done_pattern_gen #(
    parameter logic [31:0]        DIV_MAX   = 32'd32_499_999,
    parameter int                 PAT_LEN   = 8,
    parameter logic [PAT_LEN-1:0] PATTERN   = 8'b0000_0101,
    parameter int                 CODE_W    = 4,
    parameter int                 GAP_TICKS = 4
) (
    input  logic              cfg_clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              done_o,
    output logic              done_ts_o,
    output logic              tick_o,
    output logic [1:0]        mode_o
);

    localparam int CNT_W = $clog2({1'b0, DIV_MAX} + 33'd1);
    localparam logic [CNT_W-1:0] CNT_TERM = DIV_MAX[CNT_W-1:0];

    localparam int IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_CODE    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    mode_e             mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              phase_q, phase_d;
    logic              done_q, done_d;
    logic              ts_q, ts_d;

    logic              boundary;
    logic              restart;
    mode_e             mode_eff;
    logic [IDX_W-1:0]  idx_eff;
    state_e            state_eff;
    logic              phase_eff;

    // Prescaler: count 0..DIV_MAX, wrap, and flag the terminal count as next cycle's tick.
    always_comb begin
        cnt_d  = (cnt_q == CNT_TERM) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_TERM);
    end

    // Sequencer: on each tick resolve the mode boundary, restart on a mode change, then step the active mode.
    always_comb begin
        mode_d    = mode_q;
        idx_d     = idx_q;
        state_d   = state_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        phase_d   = phase_q;
        done_d    = done_q;
        ts_d      = ts_q;
        boundary  = 1'b0;
        restart   = 1'b0;
        mode_eff  = mode_q;
        idx_eff   = idx_q;
        state_eff = state_q;
        phase_eff = phase_q;

        if (tick_q) begin
            case (mode_q)
                MODE_OFF:     boundary = 1'b1;
                MODE_BLINK:   boundary = 1'b1;
                MODE_PATTERN: boundary = (idx_q == IDX_LAST);
                MODE_CODE:    boundary = (state_q == S_GAP) && (gap_q == '0);
            endcase

            if (boundary) begin
                mode_eff = mode_e'(mode_i);
                restart  = (mode_e'(mode_i) != mode_q);
            end

            if (restart) begin
                idx_eff   = '0;
                state_eff = S_LOAD;
                phase_eff = 1'b0;
            end

            mode_d  = mode_eff;
            idx_d   = idx_eff;
            state_d = state_eff;
            phase_d = phase_eff;

            case (mode_eff)
                MODE_OFF: begin
                    done_d = 1'b0;
                    ts_d   = 1'b1;
                end
                MODE_BLINK: begin
                    done_d  = ~phase_eff;
                    phase_d = ~phase_eff;
                    ts_d    = 1'b0;
                end
                MODE_PATTERN: begin
                    done_d = PATTERN[idx_eff];
                    idx_d  = (idx_eff == IDX_LAST) ? '0 : idx_eff + IDX_W'(1);
                    ts_d   = 1'b0;
                end
                MODE_CODE: begin
                    ts_d = 1'b0;
                    case (state_eff)
                        S_LOAD: begin
                            rem_d = code_i;
                            if (code_i == '0) begin
                                state_d = S_GAP;
                                gap_d   = GAP_INIT;
                                done_d  = 1'b0;
                            end else begin
                                state_d = S_HI;
                                done_d  = 1'b1;
                            end
                        end
                        S_HI: begin
                            state_d = S_LO;
                            done_d  = 1'b0;
                            rem_d   = rem_q - CODE_W'(1);
                        end
                        S_LO: begin
                            if (rem_q == '0) begin
                                state_d = S_GAP;
                                gap_d   = GAP_INIT;
                                done_d  = 1'b0;
                            end else begin
                                state_d = S_HI;
                                done_d  = 1'b1;
                            end
                        end
                        S_GAP: begin
                            done_d = 1'b0;
                            if (gap_q == '0) begin
                                state_d = S_LOAD;
                            end else begin
                                gap_d = gap_q - GAP_W'(1);
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // State registers with synchronous reset; outputs are registered so they move one cycle after the tick.
    always_ff @(posedge cfg_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_OFF;
            idx_q   <= '0;
            state_q <= S_LOAD;
            rem_q   <= '0;
            gap_q   <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            ts_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            ts_q    <= ts_d;
        end
    end

    assign done_o    = done_q;
    assign done_ts_o = ts_q;
    assign tick_o    = tick_q;
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_startup_done_pattern_gen.sv
// Self-checking bench for startup_done_pattern_gen with a small prescaler.
// Each tick step queues the expected {done, ts, mode}; the entry is popped
// and compared right after the edge that consumes the tick.
module tb_startup_done_pattern_gen;

    logic       cfg_clk = 1'b0;
    logic       rst;
    logic [1:0] mode_i;
    logic [3:0] code_i;
    logic       done_o;
    logic       done_ts_o;
    logic       tick_o;
    logic [1:0] mode_o;

    int         checks;
    int         failures;
    logic [3:0] exp_q [$];
    logic [3:0] last_exp;

    bit pat_seq   [8]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    bit code3_seq [11] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    bit code5_seq [25] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,
                           1, 0, 1, 0, 0, 0, 0, 0, 0, 1};

    startup_done_pattern_gen #(
        .DIV_MAX   (32'd3),
        .PAT_LEN   (8),
        .PATTERN   (8'b0000_0101),
        .CODE_W    (4),
        .GAP_TICKS (4)
    ) dut (
        .cfg_clk   (cfg_clk),
        .rst       (rst),
        .mode_i    (mode_i),
        .code_i    (code_i),
        .done_o    (done_o),
        .done_ts_o (done_ts_o),
        .tick_o    (tick_o),
        .mode_o    (mode_o)
    );

    // 10 ns clock
    always #5 cfg_clk = ~cfg_clk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst    = 1'b1;
        mode_i = 2'd0;
        code_i = 4'd0;
        repeat (2) @(posedge cfg_clk);
        @(negedge cfg_clk);
        checkVal("reset_state", {4'b0, tick_o, done_o, done_ts_o, mode_o == 2'd0}, 8'b0000_0011);
        rst      = 1'b0;
        last_exp = 4'b0100;
        exp_q.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] c,
                                 input logic exp_done, input logic exp_ts, input logic [1:0] exp_mode);
        mode_i = m;
        code_i = c;
        exp_q.push_back({exp_done, exp_ts, exp_mode});
    endtask

    task automatic checkOutput(input string tag);
        int         waited;
        logic [3:0] exp_v;
        @(negedge cfg_clk);
        waited = 1;
        while (tick_o !== 1'b1 && waited < 12) begin
            @(negedge cfg_clk);
            waited++;
        end
        checkVal({tag, "_period"}, 8'(waited), 8'd4);
        checkVal({tag, "_hold"}, {4'b0, done_o, done_ts_o, mode_o}, {4'b0, last_exp});
        @(posedge cfg_clk);
        #1;
        if (exp_q.size() == 0) begin
            exp_v = 4'bxxxx;
        end else begin
            exp_v = exp_q.pop_front();
        end
        checkVal({tag, "_out"}, {4'b0, done_o, done_ts_o, mode_o}, {4'b0, exp_v});
        checkVal({tag, "_ticklow"}, {7'b0, tick_o}, 8'd0);
        last_exp = exp_v;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        mode_i   = 2'd0;
        code_i   = 4'd0;
        last_exp = 4'b0100;

        // OFF: pin released, done low, tick every 4 cycles
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'd0, 4'd0, 1'b0, 1'b1, 2'd0);
            checkOutput($sformatf("t1_off%0d", i));
        end

        // BLINK from reset: first tick drives 1, then toggles
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'd1, 4'd0, (i % 2 == 0), 1'b0, 2'd1);
            checkOutput($sformatf("t2_blink%0d", i));
        end

        // PATTERN twice through, then a BLINK request mid-pattern waits for the wrap tick
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'd2, 4'd0, pat_seq[i % 8], 1'b0, 2'd2);
            checkOutput($sformatf("t3_pat%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 7) begin
                applyStimulus((i >= 2) ? 2'd1 : 2'd2, 4'd0, pat_seq[i], 1'b0, 2'd2);
            end else begin
                applyStimulus(2'd1, 4'd0, (i % 2 == 1), 1'b0, 2'd1);
            end
            checkOutput($sformatf("t3_sw%0d", i));
        end

        // CODE 3: one full burst, then a code-0 burst (5 ticks), then code 1 shows the period
        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(2'd3, 4'd3, code3_seq[i], 1'b0, 2'd3);
            checkOutput($sformatf("t4_c3_%0d", i));
        end
        applyStimulus(2'd3, 4'd0, 1'b0, 1'b0, 2'd3);
        checkOutput("t4_c0_load");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd3, 4'd1, 1'b0, 1'b0, 2'd3);
            checkOutput($sformatf("t4_c0_gap%0d", i));
        end
        applyStimulus(2'd3, 4'd1, 1'b1, 1'b0, 2'd3);
        checkOutput("t4_c1_load");
        applyStimulus(2'd3, 4'd1, 1'b0, 1'b0, 2'd3);
        checkOutput("t4_c1_hi");

        // CODE 5 with code_i changed to 2 after the second pulse
        doReset();
        for (int i = 0; i < 25; i++) begin
            applyStimulus(2'd3, (i >= 3) ? 4'd2 : 4'd5, code5_seq[i], 1'b0, 2'd3);
            checkOutput($sformatf("t5_c5_%0d", i));
        end

        // Reset while the code FSM sits in S_HI
        doReset();
        applyStimulus(2'd3, 4'd3, 1'b1, 1'b0, 2'd3);
        checkOutput("t6_entry");
        @(negedge cfg_clk);
        rst = 1'b1;
        @(posedge cfg_clk);
        #1;
        checkVal("t6_rst_outputs", {4'b0, tick_o, done_o, done_ts_o, mode_o == 2'd0}, 8'b0000_0011);
        checkVal("t6_rst_mode", {6'b0, mode_o}, 8'd0);
        @(negedge cfg_clk);
        rst      = 1'b0;
        last_exp = 4'b0100;
        exp_q.delete();
        applyStimulus(2'd3, 4'd3, 1'b1, 1'b0, 2'd3);
        checkOutput("t6_after");
        applyStimulus(2'd3, 4'd3, 1'b0, 1'b0, 2'd3);
        checkOutput("t6_after_hi");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
